// File: rtl/ppa_pkg.sv
// ppa_pkg: shared types and prefix-tree wiring helpers for the pipelined prefix subtractor.
// Flag bits in the stage payloads exist only when PPA_SUB_FLAGS_EN is defined.
package ppa_pkg;
    localparam int PPA_WIDTH     = 32;
    localparam int PPA_LEVELS    = 5;
    localparam int PPA_S2_LEVELS = 3;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    typedef struct packed {
        gp_t [PPA_WIDTH-1:0] gp;
        logic                cin;
`ifdef PPA_SUB_FLAGS_EN
        logic                a31;
        logic                b31;
`endif
    } s1_t;

    typedef struct packed {
        gp_t [PPA_WIDTH-1:0]  gp;
        logic [PPA_WIDTH-1:0] p;
        logic                 cin;
`ifdef PPA_SUB_FLAGS_EN
        logic                 a31;
        logic                 b31;
`endif
    } s2_t;

    typedef struct packed {
        logic [PPA_WIDTH-1:0] d;
        logic                 bout;
`ifdef PPA_SUB_FLAGS_EN
        logic                 z;
        logic                 n;
        logic                 v;
`endif
    } s3_t;

    // Levels 1..PPA_LEVELS build prefixes on odd bits; level PPA_LEVELS+1 fixes up even bits.
    function automatic bit lf_hit(input int l, input int i);
        if (l > PPA_LEVELS) return (i % 2 == 0) && (i > 0);
        return (i % 2 == 1) && (l == 1 || ((i >> (l - 1)) & 1) == 1);
    endfunction

    function automatic int lf_src(input int l, input int i);
        return (l == 1 || l > PPA_LEVELS) ? i - 1 : ((i >> (l - 1)) << (l - 1)) - 1;
    endfunction
endpackage

// File: rtl/ppa_black_cell.sv
// ppa_black_cell: prefix combine of a high group (gi, pi) with the adjacent low group (gj, pj).
module ppa_black_cell (
    input  logic gi,
    input  logic pi,
    input  logic gj,
    input  logic pj,
    output logic g,
    output logic p
);
    assign g = gi | (pi & gj);
    assign p = pi & pj;
endmodule

// File: rtl/ppa_sub_pipe_32bits.sv
// ppa_sub_pipe_32bits: 3-stage Ladner-Fischer subtractor D = A - B - Bin with valid/ready on both sides.
// Define PPA_SUB_FLAGS_EN to add registered Z/N/V flag outputs.
module ppa_sub_pipe_32bits
    import ppa_pkg::*;
#(
    parameter int WIDTH = PPA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef PPA_SUB_FLAGS_EN
    output logic             Z,
    output logic             N,
    output logic             V,
`endif
    output logic             Bout
);
    logic v1, v2, v3, en1, en2, en3;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    s3_t  s3_d, s3_q;
    logic [WIDTH-1:0] c;
    // t[0..3]: tree levels before the s2 register, t[4..7]: after it (t[7] = full prefixes)
    gp_t [WIDTH-1:0] t [0:PPA_LEVELS+2];

    assign en3      = ~v3 | out_ready;
    assign en2      = ~v2 | en3;
    assign en1      = ~v1 | en2;
    assign in_ready = en1;

    always_comb begin
        s1_d = '0;
        for (int k = 0; k < WIDTH; k++) s1_d.gp[k] = '{g: A[k] & ~B[k], p: A[k] ~^ B[k]};
        s1_d.cin = ~Bin;
`ifdef PPA_SUB_FLAGS_EN
        s1_d.a31 = A[WIDTH-1];
        s1_d.b31 = B[WIDTH-1];
`endif
    end

    assign t[0]               = s1_q.gp;
    assign t[PPA_S2_LEVELS+1] = s2_q.gp;

    for (genvar l = 1; l <= PPA_LEVELS + 1; l++) begin : g_lvl
        localparam int o = l <= PPA_S2_LEVELS ? l : l + 1;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (lf_hit(l, i)) begin : g_cell
                ppa_black_cell u_cell (
                    .gi(t[o-1][i].g),
                    .pi(t[o-1][i].p),
                    .gj(t[o-1][lf_src(l, i)].g),
                    .pj(t[o-1][lf_src(l, i)].p),
                    .g (t[o][i].g),
                    .p (t[o][i].p)
                );
            end else begin : g_pass
                assign t[o][i] = t[o-1][i];
            end
        end
    end

    always_comb begin
        s2_d     = '0;
        s2_d.gp  = t[PPA_S2_LEVELS];
        for (int k = 0; k < WIDTH; k++) s2_d.p[k] = s1_q.gp[k].p;
        s2_d.cin = s1_q.cin;
`ifdef PPA_SUB_FLAGS_EN
        s2_d.a31 = s1_q.a31;
        s2_d.b31 = s1_q.b31;
`endif
    end

    always_comb begin
        for (int k = 0; k < WIDTH; k++) c[k] = t[PPA_LEVELS+2][k].g | (t[PPA_LEVELS+2][k].p & s2_q.cin);
        s3_d      = '0;
        s3_d.d    = s2_q.p ^ {c[WIDTH-2:0], s2_q.cin};
        s3_d.bout = ~c[WIDTH-1];
`ifdef PPA_SUB_FLAGS_EN
        s3_d.z    = ~|s3_d.d;
        s3_d.n    = s3_d.d[WIDTH-1];
        s3_d.v    = (s2_q.a31 ^ s2_q.b31) & (s2_q.a31 ^ s3_d.d[WIDTH-1]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
            if (en1 && in_valid) s1_q <= s1_d;
            if (en2 && v1) s2_q <= s2_d;
            if (en3 && v2) s3_q <= s3_d;
        end
    end

    assign out_valid = v3;
    assign D         = s3_q.d;
    assign Bout      = s3_q.bout;
`ifdef PPA_SUB_FLAGS_EN
    assign Z         = s3_q.z;
    assign N         = s3_q.n;
    assign V         = s3_q.v;
`endif
endmodule

// File: tb/tb_ppa_sub_pipe_32bits.sv
// tb_ppa_sub_pipe_32bits: directed vectors, backpressure, mid-flight reset and random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_ppa_sub_pipe_32bits;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, Bin = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        in_ready, out_valid, Bout;
    logic [31:0] D;
    logic [35:0] obs, held;
    logic [35:0] q[$];
    logic        stall_prev = 1'b0;
    int          errors = 0, checks = 0, popped = 0;
`ifdef PPA_SUB_FLAGS_EN
    localparam int CW = 36;
    logic Z, N, V;
    assign obs = {V, N, Z, Bout, D};
`else
    localparam int CW = 33;
    assign obs = {3'b000, Bout, D};
`endif

    ppa_sub_pipe_32bits dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready), .D(D),
`ifdef PPA_SUB_FLAGS_EN
        .Z(Z), .N(N), .V(V),
`endif
        .Bout(Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {V, N, Z, Bout, D} from plain unsigned/signed arithmetic
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] r;
        r = {1'b0, a} - {1'b0, b} - 33'(bin);
        return {(a[31] ^ b[31]) & (a[31] ^ r[31]), r[31], r[31:0] == 32'd0, r};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", obs[CW-1:0], held[CW-1:0]);
            end
            if (in_valid && in_ready) q.push_back(model(A, B, Bin));
            if (out_valid && out_ready) begin
                chk("sb_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    held = q.pop_front();
                    chk("sb_result", obs[CW-1:0], held[CW-1:0]);
                    popped++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held = obs;
        end
    end

    task automatic send_lat(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                            input logic [31:0] d, input logic bout, input logic [2:0] fl);
        logic [35:0] e;
        e = {fl, bout, d};
        out_ready = 1'b1;
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(negedge clk) chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk) chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk) chk({tag, "_lat2"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk) chk({tag, "_lat3"}, out_valid, 1);
        chk(tag, obs[CW-1:0], e[CW-1:0]);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_a [4];
        int p0;
        logic stale;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", obs[CW-1:0], 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk) chk("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        send_lat("v5m3", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 3'b000);
        send_lat("v0m1", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 3'b010);
        send_lat("vovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFE, 1'b0, 3'b100);
        send_lat("vzero", 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 3'b001);
        send_lat("v0b1", 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 3'b010);
        send_lat("vffb1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 3'b010);

        // three beats fill the stalled pipe, the fourth waits at the input
        bp_a = '{32'h10, 32'h2000, 32'h30_0000, 32'h4000_0000};
        out_ready = 1'b0;
        p0 = popped;
        for (int k = 0; k < 3; k++) begin
            A = bp_a[k]; B = 32'h1; Bin = 1'b0; in_valid = 1'b1;
            @(negedge clk) chk("bp_rdy", in_ready, 1);
            @(posedge clk); #1;
        end
        A = bp_a[3];
        @(negedge clk);
        chk("bp_full", in_ready, 0);
        chk("bp_valid", out_valid, 1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk) chk("bp_hold", in_ready, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk) chk("bp_release", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int n = 0; n < 20 && popped - p0 < 4; n++) @(negedge clk);
        chk("bp_drain", popped - p0, 4);
        @(posedge clk); #1;

        // reset with two beats in flight
        out_ready = 1'b0;
        A = 32'hAAAA_0000; B = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1 A = 32'hBBBB_0000;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", obs[CW-1:0], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        repeat (5) @(negedge clk) stale |= out_valid;
        chk("no_stale", stale, 0);
        @(posedge clk); #1;
        send_lat("post_rst", 32'h100, 32'hFF, 1'b1, 32'h0, 1'b0, 3'b001);

        for (int n = 0; n < 20000; n++) begin
            in_valid  = ($urandom % 4) != 0;
            A         = pick();
            B         = pick();
            Bin       = $urandom % 2;
            out_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
